// File: rtl/eth_pkg.sv
// Shared constants, state encoding and helpers for the Ethernet serial receive front end.
package eth_pkg;

  localparam int          HDR_LEN     = 6;
  localparam logic [7:0]  BCAST_BYTE  = 8'hFF;
  localparam logic [47:0] DEFAULT_MAC = 48'hFEFAF6F2EEEA;

  typedef logic [1:0] state_t;

  localparam state_t IDLE    = 2'd0;
  localparam state_t HEADER  = 2'd1;
  localparam state_t PAYLOAD = 2'd2;
  localparam state_t DISCARD = 2'd3;

  // Byte k of a station address in wire order (byte 0 sits in the top octet).
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] k);
    case (k)
      3'd0:    mac_byte = mac[47:40];
      3'd1:    mac_byte = mac[39:32];
      3'd2:    mac_byte = mac[31:24];
      3'd3:    mac_byte = mac[23:16];
      3'd4:    mac_byte = mac[15:8];
      default: mac_byte = mac[7:0];
    endcase
  endfunction

endpackage

// File: rtl/eth_sync_edge.sv
// Two-flop synchroniser with an edge register for rise/fall detection.
module eth_sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  // Resolve metastability over two stages, then keep the previous synced level for edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      sync <= RESET_VAL;
      prev <= RESET_VAL;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~prev;
  assign fall  = ~sync & prev;

endmodule

// File: rtl/eth_spi_rx_front.sv
// Serial receive front end: synchronises the link, assembles bytes LSB-first,
// filters on destination MAC and emits a byte-write stream plus a frame verdict.
module eth_spi_rx_front
  import eth_pkg::*;
#(
  parameter logic [47:0] MAC     = DEFAULT_MAC,
  parameter int          MAX_LEN = 1536,
  parameter int          IDX_W   = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             recv_sck,
  input  logic             recv_mosi,
  input  logic             n_recv_ss,
  input  logic             buf_busy,
  output logic             wr_en,
  output logic [7:0]       wr_data,
  output logic [IDX_W-1:0] wr_idx,
  output logic             frame_done,
  output logic [IDX_W-1:0] frame_last,
  output logic             frame_drop
);

  localparam logic [IDX_W-1:0] MAX_CNT  = IDX_W'(MAX_LEN);
  localparam logic [IDX_W-1:0] LAST_HDR = IDX_W'(HDR_LEN - 1);

  logic sck_rise, ss_fall, ss_rise, ss_level, mosi;
  logic unused_sck_level, unused_sck_fall, unused_mosi_rise, unused_mosi_fall;

  eth_sync_edge #(.RESET_VAL(1'b1)) u_sck_sync (
    .clk(clk), .rst(rst), .din(recv_sck),
    .level(unused_sck_level), .rise(sck_rise), .fall(unused_sck_fall)
  );

  eth_sync_edge #(.RESET_VAL(1'b0)) u_mosi_sync (
    .clk(clk), .rst(rst), .din(recv_mosi),
    .level(mosi), .rise(unused_mosi_rise), .fall(unused_mosi_fall)
  );

  eth_sync_edge #(.RESET_VAL(1'b1)) u_ss_sync (
    .clk(clk), .rst(rst), .din(n_recv_ss),
    .level(ss_level), .rise(ss_rise), .fall(ss_fall)
  );

  logic [1:0]       warm;
  logic             ss_armed;
  logic             ss_start;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift_reg;
  logic [7:0]       byte_reg;
  logic             byte_valid;
  logic [IDX_W-1:0] byte_cnt;
  logic             mac_ok;
  logic             bcast_ok;
  logic             end_pending;
  logic             mac_hit;
  logic             bcast_hit;
  state_t           state;

  // A select edge only starts a frame once ss has been seen idle after reset,
  // so a frame already in flight when reset releases is ignored.
  assign ss_start  = ss_fall & ss_armed;
  assign mac_hit   = mac_ok & (byte_reg == mac_byte(MAC, byte_cnt[2:0]));
  assign bcast_hit = bcast_ok & (byte_reg == BCAST_BYTE);

  // Wait for the synchroniser to refill, then arm on a genuinely idle select line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      warm     <= 2'd0;
      ss_armed <= 1'b0;
    end else if (warm != 2'd3) begin
      warm <= warm + 2'd1;
    end else if (ss_level) begin
      ss_armed <= 1'b1;
    end
  end

  // Shift serial bits in LSB-first and hand each completed byte to the control logic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt    <= 3'd0;
      shift_reg  <= 8'd0;
      byte_reg   <= 8'd0;
      byte_valid <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      if (ss_start) begin
        bit_cnt   <= 3'd0;
        shift_reg <= 8'd0;
      end else if (sck_rise) begin
        shift_reg <= {mosi, shift_reg[7:1]};
        bit_cnt   <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_reg   <= {mosi, shift_reg[7:1]};
          byte_valid <= 1'b1;
        end
      end
    end
  end

  // Frame state machine; a byte strobe always wins over the end-of-frame verdict,
  // which is deferred one cycle so frame_done never coincides with wr_en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      byte_cnt    <= '0;
      mac_ok      <= 1'b0;
      bcast_ok    <= 1'b0;
      end_pending <= 1'b0;
      wr_en       <= 1'b0;
      wr_data     <= 8'd0;
      wr_idx      <= '0;
      frame_done  <= 1'b0;
      frame_last  <= '0;
      frame_drop  <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      frame_drop <= 1'b0;
      if (ss_start) begin
        byte_cnt    <= '0;
        end_pending <= 1'b0;
        mac_ok      <= 1'b1;
        bcast_ok    <= 1'b1;
        if (buf_busy) begin
          state      <= DISCARD;
          frame_drop <= 1'b1;
        end else begin
          state      <= HEADER;
          frame_drop <= (state == HEADER) || (state == PAYLOAD);
        end
      end else if (byte_valid) begin
        if (ss_rise) end_pending <= 1'b1;
        byte_cnt <= byte_cnt + 1'b1;
        case (state)
          HEADER: begin
            wr_en    <= 1'b1;
            wr_data  <= byte_reg;
            wr_idx   <= byte_cnt;
            mac_ok   <= mac_hit;
            bcast_ok <= bcast_hit;
            if (byte_cnt == LAST_HDR) begin
              if (mac_hit || bcast_hit) begin
                state <= PAYLOAD;
              end else begin
                state      <= DISCARD;
                frame_drop <= 1'b1;
              end
            end
          end
          PAYLOAD: begin
            if (byte_cnt == MAX_CNT) begin
              state      <= DISCARD;
              frame_drop <= 1'b1;
            end else begin
              wr_en   <= 1'b1;
              wr_data <= byte_reg;
              wr_idx  <= byte_cnt;
            end
          end
          default: ;
        endcase
      end else if (ss_rise || end_pending) begin
        end_pending <= 1'b0;
        case (state)
          PAYLOAD: begin
            state <= IDLE;
            if (bit_cnt == 3'd0) begin
              frame_done <= 1'b1;
              frame_last <= byte_cnt - 1'b1;
            end else begin
              frame_drop <= 1'b1;
            end
          end
          HEADER: begin
            state      <= IDLE;
            frame_drop <= 1'b1;
          end
          DISCARD: state <= IDLE;
          default: ;
        endcase
      end
    end
  end

endmodule
